// File: rtl/ht_ptr_pkg.sv
// Shared types for the hash-table free-pointer storage.
// Default-width pointer/count types; width-parameterised modules declare their own vectors.
package ht_ptr_pkg;

  localparam int unsigned PTR_A_WIDTH = 8;

  typedef logic [PTR_A_WIDTH-1:0] ptr_t;
  typedef logic [PTR_A_WIDTH:0]   cnt_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } free_ptr_state_e;

endpackage

// File: rtl/ptr_fifo_sa.sv
// Generic show-ahead register FIFO of 2**A_WIDTH entries.
// The caller guarantees push only when not full (or when popping) and pop only when not empty.
module ptr_fifo_sa #(
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [A_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  output logic [A_WIDTH-1:0] head_o,
  output logic [A_WIDTH:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned DEPTH = 2**A_WIDTH;

  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + A_WIDTH'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (A_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (A_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the init fill defines every entry that can be read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = count_q[A_WIDTH];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/free_ptr_fifo.sv
// Free-pointer FIFO for bucket/entry memory: self-fills 0..INIT_CNT-1 after reset, then recycles pointers.
// Define FREE_PTR_DOUBLE_FREE_CHECK_EN to add a presence bitmap that rejects double frees.
module free_ptr_fifo
  import ht_ptr_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned INIT_CNT = 2**A_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               init_done_o,
  output logic               overflow_o,
  output logic               double_free_o
);

  localparam int unsigned        INIT_LAST_I = INIT_CNT - 1;
  localparam logic [A_WIDTH-1:0] INIT_LAST   = INIT_LAST_I[A_WIDTH-1:0];

  free_ptr_state_e    state_q, state_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic               overflow_q, overflow_d;

  logic               push, pop, room, dup;
  logic [A_WIDTH-1:0] push_data, head;
  logic [A_WIDTH:0]   count;
  logic               full, empty;

  ptr_fifo_sa #(.A_WIDTH(A_WIDTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;
    room       = 1'b0;
    push_data  = add_empty_ptr_i;
    case (state_q)
      INIT: begin
        push       = 1'b1;
        push_data  = init_cnt_q;
        init_cnt_d = init_cnt_q + A_WIDTH'(1);
        if (init_cnt_q == INIT_LAST) state_d = RUN;
        if (add_empty_ptr_en_i) overflow_d = 1'b1;
      end
      RUN: begin
        pop  = next_empty_ptr_rd_ack_i && !empty;
        room = !full || pop;
        if (add_empty_ptr_en_i && !room) overflow_d = 1'b1;
        push = add_empty_ptr_en_i && room && !dup;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
  localparam int unsigned DEPTH = 2**A_WIDTH;

  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  logic             double_free_q, double_free_d;

  // Freeing the head that leaves this same cycle is legitimate, not a double free.
  assign dup = (state_q == RUN) && bitmap_q[add_empty_ptr_i]
               && !(pop && (add_empty_ptr_i == head));

  always_comb begin
    bitmap_d      = bitmap_q;
    double_free_d = double_free_q;
    if (pop)  bitmap_d[head]      = 1'b0;
    if (push) bitmap_d[push_data] = 1'b1;
    if (add_empty_ptr_en_i && room && dup) double_free_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitmap_q      <= '0;
      double_free_q <= 1'b0;
    end else begin
      bitmap_q      <= bitmap_d;
      double_free_q <= double_free_d;
    end
  end

  assign double_free_o = double_free_q;
`else
  assign dup           = 1'b0;
  assign double_free_o = 1'b0;
`endif

  assign next_empty_ptr_o     = head;
  assign next_empty_ptr_val_o = (state_q == RUN) && !empty;
  assign free_cnt_o           = count;
  assign init_done_o          = (state_q == RUN);
  assign overflow_o           = overflow_q;

endmodule
